spi_over_jtag_framed: RTL and testbench

Framed, multi-chip-select JTAG-to-SPI bridge and the next generation of the single-flash spiOverJtag bridge. It is clocked from the BSCAN TCK and driven by the BSCAN SEL/CAPTURE/SHIFT/UPDATE/TDI outputs. Each DR scan carries a start bit, a header (chip select, mode, hold, length) and the payload. Over the plain bridge it adds explicit transfer length, chip-select hold across scans, abort detection and optional quad-read buffering.

---
 rtl/spi_over_jtag_framed.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_spi_over_jtag_framed.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_over_jtag_framed.sv
// ---------------------------------------------------------------------------
// spi_over_jtag_framed
//
// Framed, multi-chip-select JTAG-to-SPI bridge clocked from BSCAN TCK.
// Each DR scan carries a start bit, then a header shifted LSB first
// (cs_idx[CS_W], quad[1], hold[1], len[LEN_W]), then the payload.
//
// Optional feature macro: QUAD_READ_EN
//   defined   : quad-read path (nibble register, slot counter) is present.
//   undefined : the header quad bit is ignored; every transfer is single-bit.
//
// Ports
//   clk          BSCAN TCK, the only clock
//   rst          synchronous active-high reset
//   sel, capture, shift, update, tdi
//                BSCAN outputs for this USER chain (capture/update unused)
//   tdo          registered return data to BSCAN TDO
//   sck_en       SPI clock enable; top level forms sck = clk & sck_en
//   csn          active-low chip selects, NUM_CS wide
//   dq_o/dq_oe   flash DQ outputs / output enables (dq_o[0] = MOSI)
//   dq_i         flash DQ inputs (dq_i[1] = MISO)
//   busy         high whenever the FSM is outside IDLE
//   abort        sticky error flag (bad chip select or premature scan exit)
//   o_dbg_state  current FSM state, for observation
//
// Handshake: the bridge has no valid/ready pair. A bit is consumed on every
// clock where sel & shift ("active") is high; dropping active while in
// HDR or XFER is treated as an aborted scan.
// ---------------------------------------------------------------------------
module spi_over_jtag_framed #(
    parameter int NUM_CS = 1,
    parameter int CS_W   = 2,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              capture,
    input  logic              shift,
    input  logic              update,
    input  logic              tdi,
    output logic              tdo,
    output logic              sck_en,
    output logic [NUM_CS-1:0] csn,
    output logic [3:0]        dq_o,
    output logic [3:0]        dq_oe,
    input  logic [3:0]        dq_i,
    output logic              busy,
    output logic              abort,
    output logic [2:0]        o_dbg_state
);

    localparam int HDR_W  = CS_W + 2 + LEN_W;
    localparam int HCNT_W = $clog2(HDR_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_XFER  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;

    logic [HDR_W-1:0]    r_hdr;
    logic [HCNT_W-1:0]   r_hdr_cnt;
    logic [LEN_W-1:0]    r_len;
    logic                r_hold;
    logic [NUM_CS-1:0]   r_csn;
    logic                r_tdo;
    logic                r_abort;

    logic                w_active;
    logic [HDR_W-1:0]    w_hdr_full;
    logic                w_hdr_last;
    logic [CS_W-1:0]     w_cs;
    logic                w_hold_hdr;
    logic [LEN_W-1:0]    w_len_hdr;
    logic                w_len_zero;
    logic                w_cs_bad;
    logic [NUM_CS-1:0]   w_csn_dec;
    logic                w_quad;
    logic                w_slot0;
    logic                w_slot_last;
    logic                w_xfer_last;
    logic                w_mosi;
    logic                w_sck_en;
    logic [3:0]          w_dq_oe;

    // The header register shifts right so the first (LSB) bit ends up at
    // bit 0; w_hdr_full already includes the bit arriving this cycle.
    assign w_hdr_full = {tdi, r_hdr[HDR_W-1:1]};

`ifdef QUAD_READ_EN
    logic       r_quad;
    logic [1:0] r_slot;
    logic [3:0] r_sr;

    assign w_quad      = r_quad;
    assign w_slot0     = (r_slot == 2'd0);
    assign w_slot_last = !r_quad || (r_slot == 2'd3);
`else
    logic w_unused;

    assign w_quad      = 1'b0;
    assign w_slot0     = 1'b1;
    assign w_slot_last = 1'b1;
    assign w_unused    = ^{dq_i[3:2], dq_i[0], w_hdr_full[CS_W], capture, update};
`endif

    always_comb begin
        w_active    = sel & shift;
        w_hdr_last  = (r_hdr_cnt == HCNT_W'(HDR_W - 1));
        w_cs        = w_hdr_full[CS_W-1:0];
        w_hold_hdr  = w_hdr_full[CS_W+1];
        w_len_hdr   = w_hdr_full[HDR_W-1:CS_W+2];
        w_len_zero  = (w_len_hdr == '0);
        w_cs_bad    = ({1'b0, w_cs} >= (CS_W+1)'(NUM_CS));
        // Transfer ends when the last bit (single) or last slot of the
        // last nibble (quad) is consumed; the counter never wraps.
        w_xfer_last = w_slot_last && (r_len == LEN_W'(1));
        for (int i = 0; i < NUM_CS; i++) begin
            w_csn_dec[i] = (int'(w_cs) != i);
        end
`ifndef QUAD_READ_EN
`endif
    end

    // ---------------- next-state / combinational outputs ----------------
    always_comb begin
        w_state_nx = r_state;
        w_sck_en   = 1'b0;
        w_mosi     = 1'b0;
        w_dq_oe    = 4'b1101;

        case (r_state)
            S_IDLE: begin
                if (w_active && tdi) begin
                    w_state_nx = S_HDR;
                end
            end
            S_HDR: begin
                if (!w_active) begin
                    w_state_nx = S_IDLE;
                end else if (w_hdr_last) begin
                    if (w_cs_bad) begin
                        w_state_nx = S_ERR;
                    end else if (w_len_zero) begin
                        w_state_nx = S_DRAIN;
                    end else begin
                        w_state_nx = S_XFER;
                    end
                end
            end
            S_XFER: begin
                // sck_en is gated by active so an aborted scan stops the
                // SPI clock in the very cycle shift drops.
                w_sck_en = w_active && (!w_quad || w_slot0);
                w_mosi   = w_quad ? 1'b0 : tdi;
                w_dq_oe  = w_quad ? 4'b0000 : 4'b1101;
                if (!w_active) begin
                    w_state_nx = S_IDLE;
                end else if (w_xfer_last) begin
                    w_state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nx = S_IDLE;
            end
            S_ERR: begin
                if (!w_active) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_hdr     <= '0;
            r_hdr_cnt <= '0;
            r_len     <= '0;
            r_hold    <= 1'b0;
            r_csn     <= '1;
            r_tdo     <= 1'b0;
            r_abort   <= 1'b0;
`ifdef QUAD_READ_EN
            r_quad    <= 1'b0;
            r_slot    <= 2'd0;
            r_sr      <= 4'd0;
`endif
        end else begin
            r_state <= w_state_nx;
            case (r_state)
                S_IDLE: begin
                    r_tdo <= 1'b0;
                    if (w_active && tdi) begin
                        r_hdr_cnt <= '0;
                    end
                end
                S_HDR: begin
                    r_tdo <= 1'b0;
                    if (!w_active) begin
                        // premature exit: release everything, discard hold
                        r_abort <= 1'b1;
                        r_csn   <= '1;
                        r_hold  <= 1'b0;
                    end else begin
                        r_hdr     <= w_hdr_full;
                        r_hdr_cnt <= r_hdr_cnt + HCNT_W'(1);
                        if (w_hdr_last) begin
                            r_len <= w_len_hdr;
`ifdef QUAD_READ_EN
                            r_quad <= w_hdr_full[CS_W];
                            r_slot <= 2'd0;
`endif
                            if (w_cs_bad) begin
                                r_abort <= 1'b1;
                                r_csn   <= '1;
                                r_hold  <= 1'b0;
                            end else begin
                                r_hold <= w_hold_hdr;
                                // len=0 frames only update hold; a held
                                // select is then released when DRAIN ends.
                                if (!w_len_zero) begin
                                    r_abort <= 1'b0;
                                    r_csn   <= w_csn_dec;
                                end
                            end
                        end
                    end
                end
                S_XFER: begin
                    if (!w_active) begin
                        r_abort <= 1'b1;
                        r_csn   <= '1;
                        r_hold  <= 1'b0;
                        r_tdo   <= 1'b0;
                    end else begin
`ifdef QUAD_READ_EN
                        if (r_quad) begin
                            r_slot <= r_slot + 2'd1;
                            // Slot 0 captures the nibble and presents b3;
                            // slots 1..3 walk b2..b0 out, so b0 lands on
                            // the following slot 0 (or DRAIN).
                            if (r_slot == 2'd0) begin
                                r_sr  <= dq_i;
                                r_tdo <= dq_i[3];
                            end else begin
                                r_sr  <= {r_sr[2:0], 1'b0};
                                r_tdo <= r_sr[2];
                            end
                            if (r_slot == 2'd3) begin
                                r_len <= r_len - LEN_W'(1);
                            end
                        end else begin
                            r_tdo <= dq_i[1];
                            r_len <= r_len - LEN_W'(1);
                        end
`else
                        r_tdo <= dq_i[1];
                        r_len <= r_len - LEN_W'(1);
`endif
                    end
                end
                S_DRAIN: begin
                    // tdo keeps the last returned bit for this cycle
                    if (!r_hold) begin
                        r_csn <= '1;
                    end
                end
                S_ERR: begin
                    r_tdo <= 1'b0;
                end
                default: begin
                    r_tdo <= 1'b0;
                end
            endcase
        end
    end

    assign tdo         = r_tdo;
    assign sck_en      = w_sck_en;
    assign csn         = r_csn;
    assign dq_o        = {2'b11, 1'b0, w_mosi};
    assign dq_oe       = w_dq_oe;
    assign busy        = (r_state != S_IDLE);
    assign abort       = r_abort;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_over_jtag_framed.sv
// ---------------------------------------------------------------------------
// tb_spi_over_jtag_framed
//
// Directed bench for spi_over_jtag_framed (NUM_CS=2, CS_W=2, LEN_W=16).
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// well away from the rising (active) edge.
// ---------------------------------------------------------------------------
module tb_spi_over_jtag_framed;

    localparam int NUM_CS = 2;
    localparam int CS_W   = 2;
    localparam int LEN_W  = 16;
    localparam int HDR_W  = CS_W + 2 + LEN_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              sel, capture, shift, update, tdi;
    logic              tdo, sck_en, busy, abort;
    logic [NUM_CS-1:0] csn;
    logic [3:0]        dq_o, dq_oe, dq_i;
    logic [2:0]        dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // sampled outputs
    logic              s_tdo, s_sck, s_busy, s_abort;
    logic [NUM_CS-1:0] s_csn;
    logic [3:0]        s_dqo, s_oe;

    // per-frame observations
    logic [31:0]       f_mosi, f_tdo_lsb, f_tdo_msb, f_sck_pat;
    int                f_sck_cnt;
    logic [3:0]        f_oe_x, f_oe_or;
    logic [NUM_CS-1:0] f_csn_hfirst, f_csn_hlast, f_csn_x, f_csn_drain, f_csn_after;
    logic              f_abort_x, f_abort_after, f_busy_after;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    spi_over_jtag_framed #(
        .NUM_CS (NUM_CS),
        .CS_W   (CS_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .capture     (capture),
        .shift       (shift),
        .update      (update),
        .tdi         (tdi),
        .tdo         (tdo),
        .sck_en      (sck_en),
        .csn         (csn),
        .dq_o        (dq_o),
        .dq_oe       (dq_oe),
        .dq_i        (dq_i),
        .busy        (busy),
        .abort       (abort),
        .o_dbg_state (dbg_state)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic sample();
        s_tdo   = tdo;
        s_sck   = sck_en;
        s_busy  = busy;
        s_abort = abort;
        s_csn   = csn;
        s_dqo   = dq_o;
        s_oe    = dq_oe;
    endtask

    task automatic step(input logic a_shift, input logic a_tdi, input logic [3:0] a_dq);
        @(negedge clk);
        sel     = 1'b1;
        shift   = a_shift;
        tdi     = a_tdi;
        dq_i    = a_dq;
        capture = 1'b0;
        update  = 1'b0;
        #1;
        sample();
    endtask

    task automatic send_header(input logic [CS_W-1:0] a_cs, input logic a_quad,
                               input logic a_hold, input logic [LEN_W-1:0] a_len);
        logic [HDR_W-1:0] h;
        h = {a_len, a_hold, a_quad, a_cs};
        step(1'b1, 1'b1, 4'h0);
        for (int i = 0; i < HDR_W; i++) begin
            step(1'b1, h[i], 4'h0);
            if (i == 0)         f_csn_hfirst = s_csn;
            if (i == HDR_W - 1) f_csn_hlast  = s_csn;
        end
    endtask

    // Full scan: start bit, header, XFER, DRAIN, then one Exit1 cycle.
    // Quad payload: nibble k is a_miso[4k+3:4k].
    task automatic run_frame(input logic [CS_W-1:0] a_cs, input logic a_quad,
                             input logic a_hold, input int a_len,
                             input logic [31:0] a_payload, input logic [31:0] a_miso);
        logic eff_quad;
        int   n_cyc;
        logic [3:0] nib;
`ifdef QUAD_READ_EN
        eff_quad = a_quad;
`else
        eff_quad = 1'b0;
`endif
        n_cyc = eff_quad ? 4 * a_len : a_len;
        f_mosi = '0; f_tdo_lsb = '0; f_tdo_msb = '0; f_sck_pat = '0;
        f_sck_cnt = 0; f_oe_x = 'x; f_oe_or = '0; f_csn_x = 'x; f_abort_x = 1'bx;
        send_header(a_cs, a_quad, a_hold, LEN_W'(a_len));
        for (int n = 0; n < n_cyc; n++) begin
            if (eff_quad) begin
                nib = a_miso[4*(n/4) +: 4];
                step(1'b1, 1'b0, nib);
            end else begin
                step(1'b1, a_payload[n], {2'b00, a_miso[n], 1'b0});
            end
            if (n == 0) begin
                f_oe_x    = s_oe;
                f_csn_x   = s_csn;
                f_abort_x = s_abort;
            end
            f_mosi[n] = s_dqo[0];
            f_oe_or   = f_oe_or | s_oe;
            f_sck_cnt = f_sck_cnt + int'(s_sck);
            f_sck_pat = {f_sck_pat[30:0], s_sck};
            if (n >= 1) begin
                f_tdo_lsb[n-1] = s_tdo;
                f_tdo_msb      = {f_tdo_msb[30:0], s_tdo};
            end
        end
        step(1'b1, 1'b0, 4'h0);
        if (n_cyc > 0) begin
            f_tdo_lsb[n_cyc-1] = s_tdo;
            f_tdo_msb          = {f_tdo_msb[30:0], s_tdo};
        end
        f_sck_cnt   = f_sck_cnt + int'(s_sck);
        f_csn_drain = s_csn;
        step(1'b0, 1'b0, 4'h0);
        f_csn_after   = s_csn;
        f_busy_after  = s_busy;
        f_abort_after = s_abort;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; sel = 1'b0; shift = 1'b0; tdi = 1'b0;
        capture = 1'b0; update = 1'b0; dq_i = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        sample();
        check("rst_tdo",   s_tdo,   1'b0);
        check("rst_sck",   s_sck,   1'b0);
        check("rst_csn",   s_csn,   2'b11);
        check("rst_dqo",   s_dqo,   4'b1100);
        check("rst_dqoe",  s_oe,    4'b1101);
        check("rst_busy",  s_busy,  1'b0);
        check("rst_abort", s_abort, 1'b0);

        // single, cs0, len 8, payload 0x9F, MISO 0xC2
        run_frame(2'd0, 1'b0, 1'b0, 8, 32'h9F, 32'hC2);
        check("s_mosi",      f_mosi,       32'h0000_009F);
        check("s_sck_cnt",   f_sck_cnt,    8);
        check("s_tdo",       f_tdo_lsb,    32'h0000_00C2);
        check("s_csn_hlast", f_csn_hlast,  2'b11);
        check("s_csn_xfer",  f_csn_x,      2'b10);
        check("s_oe_xfer",   f_oe_x,       4'b1101);
        check("s_csn_after", f_csn_after,  2'b11);
        check("s_busy_after",f_busy_after, 1'b0);

        // hold across scans on cs1
        run_frame(2'd1, 1'b0, 1'b1, 8, 32'h5A, 32'h3C);
        check("hA_tdo",       f_tdo_lsb,   32'h0000_003C);
        check("hA_csn_after", f_csn_after, 2'b01);
        repeat (3) step(1'b0, 1'b0, 4'h0);
        check("h_csn_idle",   s_csn,       2'b01);
        run_frame(2'd1, 1'b0, 1'b0, 24, 32'hAB_CDEF, 32'h12_3456);
        check("hB_csn_hdr",   f_csn_hfirst, 2'b01);
        check("hB_mosi",      f_mosi,      32'h00AB_CDEF);
        check("hB_tdo",       f_tdo_lsb,   32'h0012_3456);
        check("hB_sck_cnt",   f_sck_cnt,   24);
        check("hB_csn_drain", f_csn_drain, 2'b01);
        check("hB_csn_after", f_csn_after, 2'b11);

        // len=0 frame releases a held select
        run_frame(2'd0, 1'b0, 1'b1, 4, 32'h6, 32'h9);
        check("r_csn_held",   f_csn_after, 2'b10);
        run_frame(2'd0, 1'b0, 1'b0, 0, 32'h0, 32'h0);
        check("r_sck_cnt",    f_sck_cnt,   0);
        check("r_csn_drain",  f_csn_drain, 2'b10);
        check("r_csn_after",  f_csn_after, 2'b11);

`ifdef QUAD_READ_EN
        // quad read, len 2, nibbles 0xA then 0x5
        run_frame(2'd0, 1'b1, 1'b0, 2, 32'h0, 32'h5A);
        check("q_tdo",       f_tdo_msb,   32'h0000_00A5);
        check("q_sck_pat",   f_sck_pat,   32'h0000_0088);
        check("q_oe_or",     f_oe_or,     4'b0000);
        check("q_csn_xfer",  f_csn_x,     2'b10);
        check("q_csn_after", f_csn_after, 2'b11);
`else
        // quad bit ignored: runs as a single-bit transfer
        run_frame(2'd0, 1'b1, 1'b0, 4, 32'h6, 32'h9);
        check("q_mosi",      f_mosi,      32'h0000_0006);
        check("q_sck_cnt",   f_sck_cnt,   4);
        check("q_tdo",       f_tdo_lsb,   32'h0000_0009);
        check("q_oe_xfer",   f_oe_x,      4'b1101);
        check("q_csn_after", f_csn_after, 2'b11);
`endif

        // bad chip select (cs_idx=3 with NUM_CS=2)
        send_header(2'd3, 1'b0, 1'b0, 16'd8);
        f_sck_cnt = 0;
        f_tdo_msb = '0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 4'hF);
            f_sck_cnt = f_sck_cnt + int'(s_sck);
            f_tdo_msb = {f_tdo_msb[30:0], s_tdo};
        end
        check("e_sck_cnt", f_sck_cnt, 0);
        check("e_tdo",     f_tdo_msb, 32'h0);
        check("e_csn",     s_csn,     2'b11);
        check("e_abort",   s_abort,   1'b1);
        check("e_busy",    s_busy,    1'b1);
        step(1'b0, 1'b0, 4'h0);
        check("e_busy_exit", s_busy,  1'b1);
        step(1'b0, 1'b0, 4'h0);
        check("e_busy_idle", s_busy,  1'b0);
        check("e_abort_sticky", s_abort, 1'b1);

        // shift drops after 3 of 8 XFER bits
        send_header(2'd0, 1'b0, 1'b0, 16'd8);
        step(1'b1, 1'b1, 4'h2);
        check("d_abort_clr", s_abort, 1'b0);
        check("d_sck_on",    s_sck,   1'b1);
        step(1'b1, 1'b0, 4'h2);
        step(1'b1, 1'b1, 4'h2);
        step(1'b0, 1'b0, 4'h0);
        check("d_sck_drop",  s_sck,   1'b0);
        check("d_csn_drop",  s_csn,   2'b10);
        step(1'b0, 1'b0, 4'h0);
        check("d_csn_next",  s_csn,   2'b11);
        check("d_abort_set", s_abort, 1'b1);
        check("d_busy",      s_busy,  1'b0);
        run_frame(2'd1, 1'b0, 1'b0, 4, 32'hA, 32'h5);
        check("d_abort_x",   f_abort_x,     1'b0);
        check("d_tdo",       f_tdo_lsb,     32'h0000_0005);
        check("d_abort_after", f_abort_after, 1'b0);

        // synchronous reset in the middle of a transfer
`ifdef QUAD_READ_EN
        send_header(2'd0, 1'b1, 1'b0, 16'd4);
`else
        send_header(2'd0, 1'b0, 1'b0, 16'd8);
`endif
        repeat (3) step(1'b1, 1'b1, 4'hF);
        check("m_tdo_pre", s_tdo, 1'b1);
        @(negedge clk);
        rst = 1'b1; sel = 1'b1; shift = 1'b1; tdi = 1'b1; dq_i = 4'hF;
        @(posedge clk);
        #1;
        sample();
        check("m_tdo",   s_tdo,   1'b0);
        check("m_sck",   s_sck,   1'b0);
        check("m_csn",   s_csn,   2'b11);
        check("m_dqo",   s_dqo,   4'b1100);
        check("m_dqoe",  s_oe,    4'b1101);
        check("m_busy",  s_busy,  1'b0);
        check("m_abort", s_abort, 1'b0);
        @(negedge clk);
        rst = 1'b0; sel = 1'b0; shift = 1'b0; tdi = 1'b0; dq_i = 4'h0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
